dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
Shares the single-port synchronous data memory between the processor's ACCESS_MEMORY stage (cpu) and the host program-load/result-readback port (host).
- Non-pipelined: at most one outstanding transaction.
- cpu has priority.
- Host is protected from starvation by a bounded-wait counter.
- Sits between the state controller/datapath and the data memory macro.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory data width
MEM_LAT, 1, memory read latency in cycles (legal 1..3)
HOST_MAX_WAIT, 4, consecutive lost arbitrations after which host wins (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  cpu request; held with fields until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  cpu address
cpu_wdata  in  DATA_W  cpu write data
cpu_gnt  out  1  one-cycle pulse: cpu transaction issued
cpu_rvalid  out  1  one-cycle pulse: rd_data holds cpu read result
host_req  in  1  host request; held with fields until host_gnt
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-cycle pulse: host transaction issued
host_rvalid  out  1  one-cycle pulse: rd_data holds host read result
rd_data  out  DATA_W  registered read data, shared by both requesters
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; starve_cnt=0; lat_cnt=0.
  - All outputs 0, including rd_data.
  - Applies mid-transaction: a pending read is discarded, no rvalid is issued, and mem_en drops in the cycle after the reset edge.
- States: IDLE, ISSUE, WAIT, RESP. Encoding is 2-bit.
- IDLE: req sampled each cycle. Decision at the clock edge:
  - host wins if host_req && (!cpu_req || starve_cnt >= HOST_MAX_WAIT).
  - Otherwise cpu wins if cpu_req.
  - Otherwise stay in IDLE.
  - On a win, the winner's we/addr/wdata and an owner bit are registered, and the next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the registered copy; owner's gnt=1.
  - Write: next state is IDLE. Back-to-back arbitration allows the next issue 2 cycles later.
  - Read: next state is WAIT; lat_cnt=MEM_LAT.
- WAIT:
  - mem_en=0; lat_cnt decrements each cycle.
  - In the cycle lat_cnt==1, mem_rdata is captured into rd_data at the edge, and the next state is RESP.
- RESP (1 cycle): owner's rvalid=1; rd_data holds the value; next state is IDLE.
- rd_data holds its last value until the next read capture.
- Latency, with req first seen in cycle T:
  - gnt in T+1.
  - Read rvalid in T+2+MEM_LAT.
  - Write committed at the end of T+1.
- starve_cnt:
  - Updated only on IDLE decision edges.
  - +1 (saturating at 15) when host_req=1 and cpu wins.
  - Cleared when host wins or host_req=0 at a decision.
- Requests are ignored outside IDLE; they are not queued. A requester may deassert or change req in the cycle after its gnt.
- mem_we is never 1 unless mem_en=1.
- At most one gnt and one rvalid are high per cycle.
- A req dropped before gnt (protocol violation) has no effect unless it was already sampled; an already-sampled request completes normally.

Decomposition:
- Shared header dmem_arb_defs.h:
  - state encodings ARB_IDLE=0, ARB_ISSUE=1, ARB_WAIT=2, ARB_RESP=3;
  - owner codes OWN_CPU=0, OWN_HOST=1.
- One natural sub-module: arb_starve_counter, a 4-bit saturating counter with inc/clr/threshold compare that outputs host_force.
- Latency counter and FSM stay inline.

Test Plan:
1. Reset mid-read: cpu read addr 0x10 issued, rst_n=0 during WAIT -> next cycle all outputs 0, busy=0, no cpu_rvalid ever; rd_data=0.
2. cpu read with MEM_LAT=2, memory preloaded 0x10=0xBEEF, cpu_req in cycle 0 -> cpu_gnt cycle 1, mem_addr=0x10 mem_en=1 cycle 1, cpu_rvalid cycle 4 with rd_data=0xBEEF, busy low cycle 5.
3. host write 0x20<-0x1234 then host read 0x20, MEM_LAT=1 -> host_gnt cycle 1 with mem_we=1; second gnt cycle 3; host_rvalid cycle 5 with rd_data=0x1234; cpu_rvalid never asserted.
4. Simultaneous req, both writes, starve_cnt=0 -> cpu_gnt first; host_gnt 2 cycles later after cpu_req drops; starve_cnt returns to 0.
5. Starvation, HOST_MAX_WAIT=4: cpu_req held continuously (back-to-back writes), host_req held -> cpu wins 4 decisions, 5th decision grants host; then cpu resumes.
6. Idle robustness: no requests for 20 cycles -> mem_en=0, busy=0, gnt/rvalid all 0, rd_data unchanged from prior read value.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter:
// FSM state and owner encodings plus the host-win arbitration rule.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } arb_owner_e;

    localparam int STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = 4'd15;

    // Wide enough for the largest legal read latency (3).
    localparam int LAT_W = 2;

    // cpu normally wins; host takes the port when alone or when it has been starved.
    function automatic logic host_wins(input logic host_req,
                                       input logic cpu_req,
                                       input logic host_force);
        return host_req && (!cpu_req || host_force);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Counts consecutive arbitrations the host lost while requesting and
// raises host_force once that count reaches the configured bound.
module arb_starve_counter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic host_force
);

    logic [STARVE_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != STARVE_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign host_force = (count >= STARVE_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Non-pipelined arbiter sharing the single-port data memory between the
// cpu ACCESS_MEMORY stage (priority) and the host load/readback port.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 16,
    parameter int MEM_LAT       = 1,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e       state;
    arb_owner_e       owner;
    logic [LAT_W-1:0] lat_cnt;

    logic host_force;
    logic host_win;
    logic cpu_win;
    logic starve_inc;
    logic starve_clr;

    assign host_win = host_wins(host_req, cpu_req, host_force);
    assign cpu_win  = cpu_req && !host_win;

    // Starvation bookkeeping only moves on IDLE decision edges.
    assign starve_inc = (state == ARB_IDLE) && cpu_win && host_req;
    assign starve_clr = (state == ARB_IDLE) && !starve_inc;

    arb_starve_counter #(
        .MAX_WAIT(HOST_MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (starve_inc),
        .clr       (starve_clr),
        .host_force(host_force)
    );

    // mem_addr/mem_wdata double as the registered copy of the winning request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            owner       <= OWN_CPU;
            lat_cnt     <= '0;
            rd_data     <= '0;
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (host_win || cpu_win) begin
                        owner     <= host_win ? OWN_HOST : OWN_CPU;
                        mem_en    <= 1'b1;
                        mem_we    <= host_win ? host_we : cpu_we;
                        mem_addr  <= host_win ? host_addr : cpu_addr;
                        mem_wdata <= host_win ? host_wdata : cpu_wdata;
                        cpu_gnt   <= cpu_win;
                        host_gnt  <= host_win;
                        busy      <= 1'b1;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_we) begin
                        busy  <= 1'b0;
                        state <= ARB_IDLE;
                    end else begin
                        lat_cnt <= LAT_W'(MEM_LAT);
                        state   <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_W'(1)) begin
                        rd_data     <= mem_rdata;
                        cpu_rvalid  <= (owner == OWN_CPU);
                        host_rvalid <= (owner == OWN_HOST);
                        state       <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
